// File: rtl/add_pkg.sv
// Shared types and helpers for the round-robin adder scheduler.
// Defaults describe the 1_7_0 operand format with four requesters.
package add_pkg;

  localparam int OPCNT_W      = 16;
  localparam int NREQ_DEF     = 4;
  localparam int SIGN_BIT_DEF = 1;
  localparam int INT_BIT_DEF  = 7;
  localparam int FLT_BIT_DEF  = 0;
  localparam int DW_DEF       = SIGN_BIT_DEF + INT_BIT_DEF + FLT_BIT_DEF;
  localparam int IDW_DEF      = (NREQ_DEF > 1) ? $clog2(NREQ_DEF) : 1;

  typedef logic [IDW_DEF-1:0] rr_ptr_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_e;

  function automatic logic [DW_DEF:0] sext(input logic [DW_DEF-1:0] x);
    return {x[DW_DEF-1], x};
  endfunction

endpackage

// File: rtl/add.sv
// Shared sign-extending adder: both operands widened by one bit, so the sum never overflows.
module add #(
  parameter  int SIGN_BIT = 1,
  parameter  int INT_BIT  = 7,
  parameter  int FLT_BIT  = 0,
  localparam int DW       = SIGN_BIT + INT_BIT + FLT_BIT
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW:0]   sum
);

  assign sum = {a[DW-1], a} + {b[DW-1], b};

endmodule

// File: rtl/add_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo NREQ.
module add_rr_pick
  import add_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any_grant
);

  always_comb begin
    int          j;
    logic [IDW-1:0] jj;
    gnt       = '0;
    idx       = '0;
    any_grant = 1'b0;
    j         = 0;
    jj        = '0;
    if (en) begin
      for (int off = 0; off < NREQ; off++) begin
        j  = (int'(ptr) + off) % NREQ;
        jj = IDW'(j);
        if (!any_grant && req[jj]) begin
          gnt[jj]   = 1'b1;
          idx       = jj;
          any_grant = 1'b1;
        end else begin
          any_grant = any_grant;
        end
      end
    end else begin
      any_grant = 1'b0;
    end
  end

endmodule

// File: rtl/add_sched.sv
// Round-robin scheduler sharing one adder among NREQ requesters, with a
// single registered response slot that can drain and reload in the same cycle.
module add_sched
  import add_pkg::*;
#(
  parameter  int NREQ     = 4,
  parameter  int SIGN_BIT = 1,
  parameter  int INT_BIT  = 7,
  parameter  int FLT_BIT  = 0,
  localparam int DW       = SIGN_BIT + INT_BIT + FLT_BIT,
  localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_a,
  input  logic [NREQ*DW-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DW:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy,
  output logic [OPCNT_W-1:0]   op_count
);

  rsp_state_e         state_q, state_d;
  logic [DW:0]        rsp_data_q, rsp_data_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [OPCNT_W-1:0] op_count_q, op_count_d;

  logic               slot_free;
  logic [NREQ-1:0]    pick_gnt;
  logic [IDW-1:0]     pick_idx;
  logic               accept;
  logic [DW-1:0]      op_a, op_b;
  logic [DW:0]        sum;

  assign slot_free = (state_q == ST_EMPTY) || rsp_ready;

  // Reset gates the grant so nothing looks accepted while the slot is being cleared.
  add_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req       (req_valid),
    .ptr       (ptr_q),
    .en        (slot_free && !rst),
    .gnt       (pick_gnt),
    .idx       (pick_idx),
    .any_grant (accept)
  );

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_a = (pick_idx == IDW'(i)) ? req_a[i*DW +: DW] : op_a;
      op_b = (pick_idx == IDW'(i)) ? req_b[i*DW +: DW] : op_b;
    end
  end

  add #(.SIGN_BIT(SIGN_BIT), .INT_BIT(INT_BIT), .FLT_BIT(FLT_BIT)) u_add (
    .a   (op_a),
    .b   (op_b),
    .sum (sum)
  );

  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    ptr_d      = ptr_q;
    op_count_d = op_count_q;
    if (accept) begin
      rsp_data_d = sum;
      rsp_id_d   = pick_idx;
      ptr_d      = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
      op_count_d = op_count_q + OPCNT_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
    case (state_q)
      ST_EMPTY: begin
        if (accept) state_d = ST_FULL;
        else        state_d = ST_EMPTY;
      end
      ST_FULL: begin
        if (accept)         state_d = ST_FULL;
        else if (rsp_ready) state_d = ST_EMPTY;
        else                state_d = ST_FULL;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      ptr_q      <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      ptr_q      <= ptr_d;
      op_count_q <= op_count_d;
    end
  end

  assign req_ready = pick_gnt;
  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = op_count_q;
  assign busy      = (state_q == ST_FULL) || (|req_valid);

endmodule

// File: tb/tb_add_sched.sv
// Directed bench for add_sched (NREQ=4, 1_7_0 format) with hand-computed expectations.
module tb_add_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [8:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;
  logic [15:0] op_count;

  int n_cmp = 0;
  int n_err = 0;

  add_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req_valid = 4'h0; rsp_ready = 1'b1; req_a = 32'h0; req_b = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1; req_a = 32'h0; req_b = 32'h0;
    #3;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %0h want 0", rsp_valid); end
    n_cmp++; if (rsp_data !== 9'h000) begin n_err++; $display("FAIL reset_rsp_data: got %h want 000", rsp_data); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    n_cmp++; if (op_count !== 16'd0) begin n_err++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %0h want 1", busy); end
    req_valid = 4'h0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %0h want 0", busy); end
  endtask

  task automatic test_single();
    apply_reset();
    set_op(2, 8'h7F, 8'h01);
    req_valid = 4'b0100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %0h want 1", rsp_valid); end
    n_cmp++; if (rsp_data !== 9'h080) begin n_err++; $display("FAIL single_data: got %h want 080", rsp_data); end
    n_cmp++; if (rsp_id !== 2'd2) begin n_err++; $display("FAIL single_id: got %0d want 2", rsp_id); end
    n_cmp++; if (op_count !== 16'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", op_count); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %0h want 0", rsp_valid); end
    n_cmp++; if (rsp_data !== 9'h080) begin n_err++; $display("FAIL drain_data_hold: got %h want 080", rsp_data); end
    n_cmp++; if (rsp_id !== 2'd2) begin n_err++; $display("FAIL drain_id_hold: got %0d want 2", rsp_id); end
  endtask

  task automatic test_negative();
    apply_reset();
    set_op(0, 8'h80, 8'h80);
    req_valid = 4'b0001;
    tick();
    n_cmp++; if (rsp_data !== 9'h100) begin n_err++; $display("FAIL neg_min_data: got %h want 100", rsp_data); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL neg_min_id: got %0d want 0", rsp_id); end
    set_op(0, 8'hFF, 8'h01);
    tick();
    req_valid = 4'b0000;
    n_cmp++; if (rsp_data !== 9'h000) begin n_err++; $display("FAIL neg_zero_data: got %h want 000", rsp_data); end
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL neg_zero_valid: got %0h want 1", rsp_valid); end
    n_cmp++; if (op_count !== 16'd2) begin n_err++; $display("FAIL neg_count: got %0d want 2", op_count); end
  endtask

  task automatic test_fairness();
    logic [8:0] exp_data [4];
    logic [3:0] exp_rdy;
    exp_data = '{9'h011, 9'h014, 9'h017, 9'h1E0};
    apply_reset();
    set_op(0, 8'h01, 8'h10);
    set_op(1, 8'h04, 8'h10);
    set_op(2, 8'h07, 8'h10);
    set_op(3, 8'hF0, 8'hF0);
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_rdy = 4'(1 << (k % 4));
      n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL fair_ready[%0d]: got %b want %b", k, req_ready, exp_rdy); end
      tick();
      n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL fair_valid[%0d]: got %0h want 1", k, rsp_valid); end
      n_cmp++; if (rsp_id !== 2'(k % 4)) begin n_err++; $display("FAIL fair_id[%0d]: got %0d want %0d", k, rsp_id, k % 4); end
      n_cmp++; if (rsp_data !== exp_data[k % 4]) begin n_err++; $display("FAIL fair_data[%0d]: got %h want %h", k, rsp_data, exp_data[k % 4]); end
    end
    req_valid = 4'b0000;
    n_cmp++; if (op_count !== 16'd6) begin n_err++; $display("FAIL fair_count: got %0d want 6", op_count); end
    tick();
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_op(0, 8'h05, 8'h03);
    set_op(1, 8'h10, 8'hFE);
    req_valid = 4'b0011;
    rsp_ready = 1'b0;
    tick();
    req_valid = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, req_ready); end
      n_cmp++; if (rsp_data !== 9'h008) begin n_err++; $display("FAIL bp_data[%0d]: got %h want 008", c, rsp_data); end
      n_cmp++; if (rsp_id !== 2'd0 || rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_id[%0d]: got id %0d valid %0h want id 0 valid 1", c, rsp_id, rsp_valid); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_release_ready: got %b want 0010", req_ready); end
    tick();
    req_valid = 4'b0000;
    n_cmp++; if (rsp_id !== 2'd1 || rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_next_id: got id %0d valid %0h want id 1 valid 1", rsp_id, rsp_valid); end
    n_cmp++; if (rsp_data !== 9'h00E) begin n_err++; $display("FAIL bp_next_data: got %h want 00e", rsp_data); end
    n_cmp++; if (op_count !== 16'd2) begin n_err++; $display("FAIL bp_count: got %0d want 2", op_count); end
  endtask

  task automatic test_ptr_skip();
    apply_reset();
    set_op(2, 8'h01, 8'h01);
    req_valid = 4'b0100;
    tick();
    set_op(1, 8'h03, 8'h04);
    req_valid = 4'b0010;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL skip_ready: got %b want 0010", req_ready); end
    tick();
    n_cmp++; if (rsp_id !== 2'd1 || rsp_data !== 9'h007) begin n_err++; $display("FAIL skip_rsp: got id %0d data %h want id 1 data 007", rsp_id, rsp_data); end
    req_valid = 4'b0110;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL skip_next_ready: got %b want 0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    n_cmp++; if (rsp_id !== 2'd2 || rsp_data !== 9'h002) begin n_err++; $display("FAIL skip_next_rsp: got id %0d data %h want id 2 data 002", rsp_id, rsp_data); end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    set_op(0, 8'h01, 8'h02);
    req_valid = 4'b0001;
    repeat (5) tick();
    n_cmp++; if (op_count !== 16'd5 || rsp_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre: got count %0d valid %0h want 5 1", op_count, rsp_valid); end
    set_op(3, 8'h11, 8'h22);
    req_valid = 4'b1001;
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %0h want 0", rsp_valid); end
    n_cmp++; if (op_count !== 16'd0) begin n_err++; $display("FAIL mid_count: got %0d want 0", op_count); end
    n_cmp++; if (rsp_data !== 9'h000) begin n_err++; $display("FAIL mid_data: got %h want 000", rsp_data); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL mid_ready: got %b want 0000", req_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_regrant: got %b want 0001", req_ready); end
    tick();
    req_valid = 4'b1000;
    n_cmp++; if (rsp_id !== 2'd0 || rsp_data !== 9'h003 || op_count !== 16'd1) begin n_err++; $display("FAIL mid_first_rsp: got id %0d data %h count %0d want 0 003 1", rsp_id, rsp_data, op_count); end
    tick();
    req_valid = 4'b0000;
    n_cmp++; if (rsp_id !== 2'd3 || rsp_data !== 9'h033) begin n_err++; $display("FAIL mid_second_rsp: got id %0d data %h want 3 033", rsp_id, rsp_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_negative();
    test_fairness();
    test_backpressure();
    test_ptr_skip();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
